// File: rtl/mode_transition_ctrl.sv
// Mode changeover controller: qualifies the PIO mode request and swaps between two
// mutually exclusive PWM drives via ramp-down, dead time and ramp-up. Optional: MODE_ESTOP_EN.
module mode_transition_ctrl #(
  parameter int SYNC_STAGES      = 2,
  parameter int STABLE_CYCLES    = 16,
  parameter int DEADTIME_CYCLES  = 64,
  parameter int RAMP_STEP_CYCLES = 4,
  parameter int PWM_WIDTH        = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mode_req,
  input  logic [PWM_WIDTH-1:0] duty_max,
`ifdef MODE_ESTOP_EN
  input  logic                 estop,
`endif
  output logic                 pwm_a,
  output logic                 pwm_b,
  output logic                 mode_active,
  output logic                 busy,
  output logic [15:0]          transition_count
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int STEP_W = $clog2(RAMP_STEP_CYCLES + 1);
  localparam int DEAD_W = $clog2(DEADTIME_CYCLES + 1);

  typedef enum logic [1:0] {S_RUN, S_RAMP_DOWN, S_DEAD, S_RAMP_UP} state_t;

  state_t               state, state_next;
  logic [SYNC_STAGES-1:0] req_sync;
  logic                 mode_sync, mode_sync_prev;
  logic [STAB_W-1:0]    stab_cnt;
  logic [STEP_W-1:0]    step_cnt;
  logic [DEAD_W-1:0]    dead_cnt;
  logic [PWM_WIDTH-1:0] duty_cur, duty_next, pwm_cnt;
  logic                 qual, step_tick, dead_done, swap, drive_en;
  logic                 estop_sync, estop_dead;

  assign mode_sync = req_sync[SYNC_STAGES-1];
  assign qual      = (state == S_RUN) && (stab_cnt == STAB_W'(STABLE_CYCLES - 1));
  assign step_tick = (step_cnt == STEP_W'(RAMP_STEP_CYCLES - 1));
  assign dead_done = (dead_cnt == DEAD_W'(DEADTIME_CYCLES - 1));

`ifdef MODE_ESTOP_EN
  logic [SYNC_STAGES-1:0] estop_q;
  assign estop_sync = estop_q[SYNC_STAGES-1];

  // Remembers that the current dead period was forced by estop, so its end must not swap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estop_q    <= '0;
      estop_dead <= 1'b0;
    end else begin
      estop_q <= {estop_q[SYNC_STAGES-2:0], estop};
      if (estop_sync)
        estop_dead <= 1'b1;
      else if (state_next != S_DEAD)
        estop_dead <= 1'b0;
    end
  end
`else
  assign estop_sync = 1'b0;
  assign estop_dead = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_RAMP_UP;
    else          state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    if (estop_sync) begin
      state_next = S_DEAD;
    end else begin
      case (state)
        S_RUN:       if (qual)                 state_next = S_RAMP_DOWN;
        S_RAMP_DOWN: if (duty_cur == '0)       state_next = S_DEAD;
        S_DEAD:      if (dead_done)            state_next = S_RAMP_UP;
        S_RAMP_UP:   if (duty_cur >= duty_max) state_next = S_RUN;
        default:                               state_next = S_RAMP_UP;
      endcase
    end
  end

  always_comb begin
    busy      = (state != S_RUN);
    duty_next = duty_cur;
    swap      = 1'b0;
    case (state)
      S_RUN: begin
        if (!qual && step_tick) begin
          if (duty_cur < duty_max)      duty_next = duty_cur + 1'b1;
          else if (duty_cur > duty_max) duty_next = duty_cur - 1'b1;
        end
      end
      S_RAMP_DOWN: if (step_tick && duty_cur != '0)      duty_next = duty_cur - 1'b1;
      S_DEAD:      swap = dead_done && !estop_dead;
      S_RAMP_UP:   if (step_tick && duty_cur < duty_max) duty_next = duty_cur + 1'b1;
      default:     duty_next = duty_cur;
    endcase
    if (estop_sync) begin
      duty_next = '0;
      swap      = 1'b0;
    end
    drive_en = (pwm_cnt < duty_cur) && (state != S_DEAD) && !estop_sync;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_sync         <= '0;
      mode_sync_prev   <= 1'b0;
      stab_cnt         <= '0;
      step_cnt         <= '0;
      dead_cnt         <= '0;
      duty_cur         <= '0;
      pwm_cnt          <= '0;
      pwm_a            <= 1'b0;
      pwm_b            <= 1'b0;
      mode_active      <= 1'b0;
      transition_count <= '0;
    end else begin
      req_sync       <= {req_sync[SYNC_STAGES-2:0], mode_req};
      mode_sync_prev <= mode_sync;

      // Saturates at the threshold so a request held through a changeover still qualifies in S_RUN.
      if (mode_sync != mode_active && mode_sync == mode_sync_prev) begin
        if (stab_cnt != STAB_W'(STABLE_CYCLES - 1)) stab_cnt <= stab_cnt + 1'b1;
      end else begin
        stab_cnt <= '0;
      end

      if (state_next != state || step_tick) step_cnt <= '0;
      else                                  step_cnt <= step_cnt + 1'b1;

      if (state_next != state || estop_sync || state != S_DEAD) dead_cnt <= '0;
      else                                                      dead_cnt <= dead_cnt + 1'b1;

      duty_cur <= duty_next;
      pwm_cnt  <= pwm_cnt + 1'b1;
      pwm_a    <= ~mode_active & drive_en;
      pwm_b    <=  mode_active & drive_en;

      if (swap) begin
        mode_active <= ~mode_active;
        if (transition_count != 16'hFFFF) transition_count <= transition_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/mode_transition_ctrl.md
Name: mode_transition_ctrl

Overview:
- Consumes the 1-bit mode request driven by the HPS-controlled mode PIO and turns it into two mutually exclusive PWM actuator drives: channel A for mode 0, channel B for mode 1.
- Synchronises and qualifies the request, then performs a safe changeover: ramp down, dead time, swap channel, ramp up.
- Sits between the PIO output and the actuator pins.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on mode_req (min 2)
- STABLE_CYCLES, 16, consecutive stable cycles needed to qualify a new request
- DEADTIME_CYCLES, 64, cycles both drives are held low between channels
- RAMP_STEP_CYCLES, 4, cycles per 1-LSB duty step
- PWM_WIDTH, 8, width of PWM counter and duty values

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- mode_req  in  1  raw mode request from PIO, 0=A, 1=B
- duty_max  in  PWM_WIDTH  target duty for the active channel, quasi-static
- pwm_a  out  1  channel A drive
- pwm_b  out  1  channel B drive
- mode_active  out  1  mode currently driven
- busy  out  1  high whenever state != S_RUN
- transition_count  out  16  completed mode swaps, saturating

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk.
- Reset values:
  - mode_active=0, duty_cur=0, pwm_a=0, pwm_b=0.
  - transition_count=0, sync flops=0, all counters=0.
  - State = S_RAMP_UP, so busy=1.
- Synchroniser: mode_req passes through SYNC_STAGES flops to give mode_sync.
- Qualifier:
  - stab_cnt increments while mode_sync != mode_active and mode_sync equals its previous-cycle value.
  - It clears on any mode_sync change, or when mode_sync == mode_active.
  - qual pulses for 1 cycle when stab_cnt reaches STABLE_CYCLES-1.
  - qual is evaluated only in S_RUN; the counter runs in all states.
- Step timer: step_cnt counts 0..RAMP_STEP_CYCLES-1 and produces a step tick on wrap. It clears on every state entry.
- FSM:
  - S_RUN:
    - On qual, go to S_RAMP_DOWN.
    - Otherwise, on each tick, duty_cur moves 1 LSB toward duty_max; it holds when equal.
  - S_RAMP_DOWN:
    - On tick, duty_cur decrements.
    - When duty_cur==0, go to S_DEAD. If entered with duty_cur==0, leave after 1 cycle.
    - Request reversal here is ignored; the changeover is committed.
  - S_DEAD:
    - Both drives are low.
    - After DEADTIME_CYCLES cycles, mode_active toggles, transition_count increments (saturates at 0xFFFF), and the FSM goes to S_RAMP_UP.
  - S_RAMP_UP:
    - On tick, duty_cur increments.
    - When duty_cur >= duty_max, go to S_RUN. If duty_max is lowered mid-ramp, S_RUN ramps it back down.
    - duty_max==0 exits immediately.
- PWM:
  - pwm_cnt is free-running over PWM_WIDTH bits and wraps 2^PWM_WIDTH-1 to 0.
  - pwm_a is registered and equals ~mode_active & (pwm_cnt < duty_cur) & (state != S_DEAD).
  - pwm_b is the same with mode_active in place of ~mode_active.
  - duty_cur=0 gives constant low; duty_cur=2^W-1 gives high for 255 of 256 cycles at W=8.
  - Output latency is 1 cycle from duty_cur/pwm_cnt.
- Invariant: pwm_a & pwm_b is never 1.
- Invariant: no drive is high in S_DEAD, or while duty_cur==0.
- Reset mid-operation: everything returns immediately to reset values with both drives low; there is no partial-state retention.

Optional Feature:
- Macro: MODE_ESTOP_EN.
- With the macro:
  - Adds input estop (1 bit, active high), synchronised by SYNC_STAGES flops.
  - While estop_sync=1, both drives are forced low on the same registered output cycle, duty_cur is cleared to 0, and the FSM is held in S_DEAD with the dead counter cleared. mode_active does not toggle.
  - On release, the dead time runs in full, then S_RAMP_UP on the same mode, without incrementing transition_count.
- Without the macro: no estop port; behaviour is exactly as above.

Test Plan (defaults, duty_max=8):
- Reset release, mode_req=0 -> busy=1; duty_cur reaches 8 after 32 cycles; S_RUN, busy=0; pwm_a high 8 of 256 cycles; pwm_b=0.
- mode_req 0->1 held -> qual after 2+16 cycles, then ramp down 32 cycles, dead 64 cycles with both low; mode_active=1, transition_count=1; pwm_b ramps to 8 in 32 cycles.
- mode_req glitch pulsed to 1 for 10 cycles -> no transition; busy stays 0; transition_count=0.
- Request reversed (back to 0) during S_RAMP_DOWN -> swap completes to mode 1, then re-qualifies and swaps back; transition_count=2; pwm_a&pwm_b never 1 (assertion).
- In S_RUN, duty_max changed 8->255 -> duty_cur climbs 1 per 4 cycles to 255; pwm_a high 255 of 256 cycles; then duty_max=0 -> both low after 1020 cycles.
- MODE_ESTOP_EN: estop asserted mid ramp-up -> drives low within SYNC_STAGES+1 cycles; on release, 64 dead cycles then ramp up on the same mode; transition_count unchanged.
